// File: rtl/fifo_wr_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin arbiter sharing the single write port of a synchronous FIFO
// between G_N_REQ requesters. Each requester offers packets on a
// valid/ready/last handshake. A grant is locked to one requester for a whole
// packet, or until G_MAX_BURST beats have been written (0 = no cap), after
// which the requester has to re-arbitrate. Writes are gated by the FIFO full
// flag, so the FIFO never sees a write while full.
//
// Parameters
//   G_N_REQ      number of requesters (2..16)
//   G_WIDTH      data width per beat
//   G_MAX_BURST  max beats per grant before a forced release; 0 = unlimited
//
// Ports
//   i_clk        clock
//   i_rst_n      asynchronous active-low reset
//   i_req_valid  per-requester beat valid
//   i_req_last   per-requester end-of-packet, qualified by valid
//   i_req_data   requester k on bits [k*G_WIDTH +: G_WIDTH]
//   o_req_ready  per-requester beat accepted this cycle
//   o_fifo_wr    FIFO write enable
//   o_fifo_data  FIFO write data (granted requester's data while locked)
//   i_fifo_full  FIFO full flag
//   o_grant      registered one-hot grant, all-zero while idle
//   o_busy       high while a grant is locked
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
   parameter int G_N_REQ     = 4,
   parameter int G_WIDTH     = 8,
   parameter int G_MAX_BURST = 16
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic [G_N_REQ-1:0]           i_req_valid,
   input  logic [G_N_REQ-1:0]           i_req_last,
   input  logic [G_N_REQ*G_WIDTH-1:0]   i_req_data,
   output logic [G_N_REQ-1:0]           o_req_ready,
   output logic                         o_fifo_wr,
   output logic [G_WIDTH-1:0]           o_fifo_data,
   input  logic                         i_fifo_full,
   output logic [G_N_REQ-1:0]           o_grant,
   output logic                         o_busy
);

   localparam int IDX_W     = $clog2(G_N_REQ);
   localparam int CNT_W_RAW = $clog2(G_MAX_BURST + 1);
   localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_LOCK = 1'b1
   } state_t;

   // Registered state
   state_t             state;
   logic [G_N_REQ-1:0] grant;
   logic [IDX_W-1:0]   grant_idx;
   logic [CNT_W-1:0]   beat_cnt;
   logic [IDX_W-1:0]   rr_last;

   // Next-state values
   state_t             state_nxt;
   logic [G_N_REQ-1:0] grant_nxt;
   logic [IDX_W-1:0]   grant_idx_nxt;
   logic [CNT_W-1:0]   beat_cnt_nxt;
   logic [IDX_W-1:0]   rr_last_nxt;

   // Per-requester data as an array so the granted lane can be indexed.
   logic [G_WIDTH-1:0] req_data_arr [G_N_REQ];

   for (genvar k = 0; k < G_N_REQ; k++) begin : g_unpack
      assign req_data_arr[k] = i_req_data[k*G_WIDTH +: G_WIDTH];
   end

   // -------------------------------------------------------------------------
   // Round-robin pick: first valid index scanning rr_last+1, rr_last+2, ...
   // modulo G_N_REQ. The requester served last is therefore checked last.
   // -------------------------------------------------------------------------
   logic             pick_found;
   logic [IDX_W-1:0] pick_idx;

   always_comb begin : rr_pick
      int               cand;
      logic [IDX_W-1:0] cand_idx;
      // NOTE: every variable written in a combinational block gets a default
      // before any branch; a path that leaves one unassigned infers a latch.
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = 0;
      cand_idx   = '0;
      for (int k = 1; k <= G_N_REQ; k++) begin
         cand     = (int'(rr_last) + k) % G_N_REQ;
         cand_idx = IDX_W'(cand);
         if (!pick_found && i_req_valid[cand_idx]) begin
            pick_found = 1'b1;
            pick_idx   = cand_idx;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Beat transfer and release conditions for the locked requester.
   // -------------------------------------------------------------------------
   logic gnt_valid;
   logic gnt_last;
   logic xfer;
   logic cap_hit;
   logic pkt_done;

   assign gnt_valid = i_req_valid[grant_idx];
   assign gnt_last  = i_req_last[grant_idx];

   // The full flag is used combinationally, so a write can never land on a
   // full FIFO regardless of when it fills.
   assign xfer = (state == ST_LOCK) && gnt_valid && !i_fifo_full;

   // beat_cnt counts beats already written in this grant, so the beat being
   // written now is the last one allowed when beat_cnt == G_MAX_BURST-1.
   if (G_MAX_BURST == 0) begin : g_no_cap
      assign cap_hit = 1'b0;
   end else begin : g_cap
      assign cap_hit = (beat_cnt == CNT_W'(G_MAX_BURST - 1));
   end

   // last and the cap coinciding on the same beat is still a single release.
   assign pkt_done = xfer && (gnt_last || cap_hit);

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin : fsm_next
      state_nxt     = state;
      grant_nxt     = grant;
      grant_idx_nxt = grant_idx;
      beat_cnt_nxt  = beat_cnt;
      rr_last_nxt   = rr_last;

      case (state)
         ST_IDLE: begin
            if (pick_found) begin
               state_nxt     = ST_LOCK;
               grant_idx_nxt = pick_idx;
               grant_nxt     = G_N_REQ'(1) << pick_idx;
               beat_cnt_nxt  = '0;
            end
         end

         ST_LOCK: begin
            // A granted requester dropping valid simply stalls; the grant is
            // held so its packet stays contiguous in the FIFO.
            if (xfer) begin
               beat_cnt_nxt = beat_cnt + 1'b1;
            end
            if (pkt_done) begin
               state_nxt   = ST_IDLE;
               grant_nxt   = '0;
               rr_last_nxt = grant_idx;
            end
         end

         default: begin
            state_nxt = ST_IDLE;
            grant_nxt = '0;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= ST_IDLE;
         grant     <= '0;
         grant_idx <= '0;
         beat_cnt  <= '0;
         rr_last   <= IDX_W'(G_N_REQ - 1);
      end else begin
         state     <= state_nxt;
         grant     <= grant_nxt;
         grant_idx <= grant_idx_nxt;
         beat_cnt  <= beat_cnt_nxt;
         rr_last   <= rr_last_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign o_fifo_wr   = xfer;
   assign o_req_ready = xfer ? grant : '0;
   assign o_fifo_data = (state == ST_LOCK) ? req_data_arr[grant_idx] : '0;
   assign o_grant     = grant;
   assign o_busy      = (state == ST_LOCK);

   // -------------------------------------------------------------------------
   // Assertions
   // -------------------------------------------------------------------------
   a_grant_onehot0 : assert property (@(posedge i_clk) disable iff (!i_rst_n)
      $onehot0(o_grant));

   a_no_wr_when_full : assert property (@(posedge i_clk) disable iff (!i_rst_n)
      o_fifo_wr |-> !i_fifo_full);

   a_ready_onehot0 : assert property (@(posedge i_clk) disable iff (!i_rst_n)
      $onehot0(o_req_ready));

   a_busy_matches_grant : assert property (@(posedge i_clk) disable iff (!i_rst_n)
      o_busy == (|o_grant));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Two arbiters side by side: dut_a with the default burst cap (16) and dut_b
// with a cap of 4. Each has its own requester drivers, FIFO-full stimulus and
// a cycle-level reference model built from the arbitration rules (owner,
// beats written in this grant, last winner). Directed scenarios also check
// grant order, write data order and write timing against hand-derived values.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int ND = 2;

   typedef struct {
      logic [W-1:0] data;
      logic         last;
      int           gap;    // idle cycles before this beat is offered
   } beat_t;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   logic [N-1:0]   req_valid [ND];
   logic [N-1:0]   req_last  [ND];
   logic [N*W-1:0] req_data  [ND];
   logic           fifo_full [ND];
   logic [N-1:0]   req_ready [ND];
   logic           fifo_wr   [ND];
   logic [W-1:0]   fifo_data [ND];
   logic [N-1:0]   grant     [ND];
   logic           busy      [ND];

   fifo_wr_arbiter #(.G_N_REQ(N), .G_WIDTH(W), .G_MAX_BURST(16)) dut_a (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_req_valid (req_valid[0]),
      .i_req_last  (req_last[0]),
      .i_req_data  (req_data[0]),
      .o_req_ready (req_ready[0]),
      .o_fifo_wr   (fifo_wr[0]),
      .o_fifo_data (fifo_data[0]),
      .i_fifo_full (fifo_full[0]),
      .o_grant     (grant[0]),
      .o_busy      (busy[0])
   );

   fifo_wr_arbiter #(.G_N_REQ(N), .G_WIDTH(W), .G_MAX_BURST(4)) dut_b (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_req_valid (req_valid[1]),
      .i_req_last  (req_last[1]),
      .i_req_data  (req_data[1]),
      .o_req_ready (req_ready[1]),
      .o_fifo_wr   (fifo_wr[1]),
      .o_fifo_data (fifo_data[1]),
      .i_fifo_full (fifo_full[1]),
      .o_grant     (grant[1]),
      .o_busy      (busy[1])
   );

   // ---------------------------------------------------------------- state
   int           n_checks = 0;
   int           n_errors = 0;
   beat_t        src_q [ND*N][$];
   int           wait_cnt [ND*N];
   logic         full_q [ND][$];
   int           full_pct;
   logic [N-1:0] rdy_s [ND];
   int           m_owner [ND];   // -1 when idle
   int           m_beats [ND];
   int           m_last  [ND];
   logic         m_wr    [ND];
   int           grant_log [ND][$];
   int           wr_log    [ND][$];
   int           wr_cyc    [ND][$];
   logic [N-1:0] prev_grant [ND];
   int           cyc;
   int           wr_while_full = 0;

   function automatic int cap_of(input int d);
      return (d == 0) ? 16 : 4;
   endfunction

   function automatic int onehot_idx(input logic [N-1:0] g);
      int idx;
      idx = -1;
      for (int r = 0; r < N; r++) if (g[r]) idx = r;
      return idx;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_seq(input string tag, input int got[$], input int exp[$]);
      check({tag, ".len"}, 32'(got.size()), 32'(exp.size()));
      foreach (exp[k])
         check($sformatf("%s[%0d]", tag, k), (k < got.size()) ? 32'(got[k]) : 32'hffff_ffff, 32'(exp[k]));
   endtask

   // ------------------------------------------------------------ stimulus
   task automatic load_pkt(input int d, input int r, input int len, input int base,
                           input int gap0, input int gap_at, input int gap_len);
      beat_t bt;
      for (int b = 0; b < len; b++) begin
         bt.data = W'(base + b);
         bt.last = (b == len - 1);
         bt.gap  = (b == 0) ? gap0 : ((b == gap_at) ? gap_len : 0);
         src_q[d*N + r].push_back(bt);
      end
   endtask

   // Requester behaviour: an offered beat is held until accepted; between
   // beats valid may go low for the beat's gap. Data/last are junk when idle.
   task automatic drive_req(input int d);
      for (int r = 0; r < N; r++) begin
         int i;
         i = d*N + r;
         if (req_valid[d][r] && rdy_s[d][r]) begin
            void'(src_q[i].pop_front());
            req_valid[d][r] = 1'b0;
         end
         if (!req_valid[d][r]) begin
            if (src_q[i].size() > 0 && wait_cnt[i] >= src_q[i][0].gap) begin
               req_valid[d][r]        = 1'b1;
               req_last[d][r]         = src_q[i][0].last;
               req_data[d][r*W +: W]  = src_q[i][0].data;
               wait_cnt[i]            = 0;
            end else begin
               if (src_q[i].size() > 0) wait_cnt[i]++;
               req_last[d][r]         = 1'($urandom);
               req_data[d][r*W +: W]  = W'($urandom);
            end
         end
      end
      rdy_s[d] = '0;
   endtask

   task automatic drive_full(input int d);
      if (full_q[d].size() > 0) fifo_full[d] = full_q[d].pop_front();
      else                      fifo_full[d] = ($urandom_range(99) < full_pct);
   endtask

   task automatic start();
      for (int d = 0; d < ND; d++) begin
         drive_req(d);
         drive_full(d);
      end
   endtask

   // ------------------------------------------------------------ model
   task automatic sample(input int d);
      logic         exp_wr;
      logic [N-1:0] exp_grant;
      logic [W-1:0] exp_data;
      string        p;
      exp_wr    = 1'b0;
      exp_grant = '0;
      exp_data  = '0;
      if (m_owner[d] >= 0) begin
         exp_grant[m_owner[d]] = 1'b1;
         exp_data = req_data[d][m_owner[d]*W +: W];
         exp_wr   = req_valid[d][m_owner[d]] && !fifo_full[d];
      end
      p = (d == 0) ? "a" : "b";
      check({p, ".grant"}, 32'(grant[d]), 32'(exp_grant));
      check({p, ".busy"},  32'(busy[d]), 32'(m_owner[d] >= 0));
      check({p, ".wr"},    32'(fifo_wr[d]), 32'(exp_wr));
      check({p, ".ready"}, 32'(req_ready[d]), exp_wr ? 32'(exp_grant) : 32'h0);
      check({p, ".data"},  32'(fifo_data[d]), 32'(exp_data));
      m_wr[d]  = exp_wr;
      rdy_s[d] = req_ready[d];
      if (fifo_wr[d] === 1'b1) begin
         wr_log[d].push_back(int'(fifo_data[d]));
         wr_cyc[d].push_back(cyc);
         if (fifo_full[d]) wr_while_full++;
      end
      if (prev_grant[d] == '0 && grant[d] != '0) grant_log[d].push_back(onehot_idx(grant[d]));
      prev_grant[d] = grant[d];
   endtask

   task automatic model_step(input int d);
      bit found;
      if (m_owner[d] < 0) begin
         found = 1'b0;
         for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_last[d] + k) % N;
            if (!found && req_valid[d][c]) begin
               found      = 1'b1;
               m_owner[d] = c;
               m_beats[d] = 0;
            end
         end
      end else if (m_wr[d]) begin
         m_beats[d]++;
         if (req_last[d][m_owner[d]] || (cap_of(d) != 0 && m_beats[d] == cap_of(d))) begin
            m_last[d]  = m_owner[d];
            m_owner[d] = -1;
         end
      end
   endtask

   // One clock: compare at negedge, advance model at posedge, drive at +1.
   task automatic cycle();
      @(negedge clk);
      for (int d = 0; d < ND; d++) sample(d);
      @(posedge clk);
      for (int d = 0; d < ND; d++) model_step(d);
      #1;
      for (int d = 0; d < ND; d++) begin
         drive_req(d);
         drive_full(d);
      end
      cyc++;
   endtask

   task automatic drain(input int budget);
      int n;
      bit pending;
      n = 0;
      do begin
         cycle();
         n++;
         pending = 1'b0;
         for (int d = 0; d < ND; d++)
            if (m_owner[d] >= 0 || req_valid[d] != '0 || full_q[d].size() > 0) pending = 1'b1;
         for (int i = 0; i < ND*N; i++)
            if (src_q[i].size() > 0) pending = 1'b1;
      end while (pending && n < budget);
      check("drain_timeout", 32'(pending), 32'h0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      for (int d = 0; d < ND; d++) begin
         req_valid[d]  = '0;
         req_last[d]   = '0;
         req_data[d]   = '0;
         fifo_full[d]  = 1'b0;
         rdy_s[d]      = '0;
         prev_grant[d] = '0;
         m_owner[d]    = -1;
         m_beats[d]    = 0;
         m_last[d]     = N - 1;
         m_wr[d]       = 1'b0;
         full_q[d].delete();
         grant_log[d].delete();
         wr_log[d].delete();
         wr_cyc[d].delete();
      end
      for (int i = 0; i < ND*N; i++) begin
         src_q[i].delete();
         wait_cnt[i] = 0;
      end
      full_pct = 0;
      cyc      = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // ------------------------------------------------------------ watchdog
   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------ sequence
   initial begin
      int e[$];
      int tot[ND];

      // Reset mid-packet: dut_a locked on requester 2 with 3 beats written.
      do_reset();
      load_pkt(0, 2, 10, 'h20, 0, -1, 0);
      start();
      repeat (4) cycle();
      check("rst.pre_grant", 32'(grant[0]), 32'h4);
      rst_n = 1'b0;
      #1;
      check("rst.grant", 32'(grant[0]), 32'h0);
      check("rst.wr",    32'(fifo_wr[0]), 32'h0);
      check("rst.busy",  32'(busy[0]), 32'h0);
      do_reset();
      load_pkt(0, 2, 1, 'h22, 0, -1, 0);
      load_pkt(0, 0, 1, 'h02, 0, -1, 0);
      start();
      drain(100);
      e = '{0, 2};
      check_seq("rst.order", grant_log[0], e);

      // All four requesters with single-beat packets, requester 0 has two.
      do_reset();
      for (int d = 0; d < ND; d++) begin
         for (int r = 0; r < N; r++) load_pkt(d, r, 1, 16*r, 0, -1, 0);
         load_pkt(d, 0, 1, 'h01, 0, -1, 0);
      end
      start();
      drain(100);
      for (int d = 0; d < ND; d++) begin
         e = '{0, 1, 2, 3, 0};
         check_seq($sformatf("rr%0d.order", d), grant_log[d], e);
         e = '{'h00, 'h10, 'h20, 'h30, 'h01};
         check_seq($sformatf("rr%0d.data", d), wr_log[d], e);
         e = '{1, 3, 5, 7, 9};
         check_seq($sformatf("rr%0d.cyc", d), wr_cyc[d], e);
      end

      // Requester 1 five beats with a 2-cycle full stall, requester 3 waiting.
      do_reset();
      load_pkt(0, 1, 5, 'h10, 0, -1, 0);
      load_pkt(0, 3, 2, 'h30, 0, -1, 0);
      full_q[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      start();
      drain(100);
      e = '{1, 3};
      check_seq("stall.order", grant_log[0], e);
      e = '{'h10, 'h11, 'h12, 'h13, 'h14, 'h30, 'h31};
      check_seq("stall.data", wr_log[0], e);
      e = '{1, 2, 5, 6, 7, 9, 10};
      check_seq("stall.cyc", wr_cyc[0], e);

      // Cap of 4: requester 0 ten-beat packet is split 4/4/2.
      do_reset();
      load_pkt(1, 0, 10, 'h00, 0, -1, 0);
      start();
      drain(100);
      e = '{0, 0, 0};
      check_seq("cap10.order", grant_log[1], e);
      e = '{1, 2, 3, 4, 6, 7, 8, 9, 11, 12};
      check_seq("cap10.cyc", wr_cyc[1], e);
      check("cap10.last", 32'(wr_log[1].size() > 0 ? wr_log[1][wr_log[1].size()-1] : -1), 32'h09);

      // Cap of 4: two six-beat packets interleave 0/1/0/1 under random full.
      do_reset();
      load_pkt(1, 0, 6, 'h00, 0, -1, 0);
      load_pkt(1, 1, 6, 'h10, 0, -1, 0);
      full_pct = 30;
      start();
      drain(300);
      e = '{0, 1, 0, 1};
      check_seq("cap6.order", grant_log[1], e);
      e = '{'h00, 'h01, 'h02, 'h03, 'h10, 'h11, 'h12, 'h13, 'h04, 'h05, 'h14, 'h15};
      check_seq("cap6.data", wr_log[1], e);

      // Cap of 4: last coincides with the cap on beat 8 -> one release only.
      do_reset();
      load_pkt(1, 0, 8, 'h40, 0, -1, 0);
      load_pkt(1, 0, 1, 'h48, 0, -1, 0);
      start();
      drain(100);
      e = '{0, 0, 0};
      check_seq("capl.order", grant_log[1], e);
      e = '{1, 2, 3, 4, 6, 7, 8, 9, 11};
      check_seq("capl.cyc", wr_cyc[1], e);

      // Granted requester 3 drops valid for 3 cycles; requester 0 must wait.
      do_reset();
      load_pkt(0, 3, 6, 'h30, 0, 2, 3);
      load_pkt(0, 0, 2, 'h00, 1, -1, 0);
      start();
      drain(100);
      e = '{3, 0};
      check_seq("drop.order", grant_log[0], e);
      e = '{'h30, 'h31, 'h32, 'h33, 'h34, 'h35, 'h00, 'h01};
      check_seq("drop.data", wr_log[0], e);
      e = '{1, 2, 6, 7, 8, 9, 11, 12};
      check_seq("drop.cyc", wr_cyc[0], e);

      // Randomized traffic on both arbiters against the reference model.
      for (int round = 0; round < 4; round++) begin
         do_reset();
         full_pct = 25;
         for (int d = 0; d < ND; d++) begin
            tot[d] = 0;
            for (int r = 0; r < N; r++) begin
               int npk;
               npk = $urandom_range(0, 3);
               for (int p = 0; p < npk; p++) begin
                  int len;
                  beat_t bt;
                  len = $urandom_range(1, 20);
                  for (int b = 0; b < len; b++) begin
                     bt.data = W'($urandom);
                     bt.last = (b == len - 1);
                     bt.gap  = $urandom_range(0, 2);
                     src_q[d*N + r].push_back(bt);
                  end
                  tot[d] += len;
               end
            end
         end
         start();
         drain(4000);
         for (int d = 0; d < ND; d++)
            check($sformatf("rand%0d.d%0d.writes", round, d), 32'(wr_log[d].size()), 32'(tot[d]));
      end

      check("wr_while_full", 32'(wr_while_full), 32'h0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
